// File: rtl/vga_sync_porch.sv
// Recovers column/row position from the raw Sync_Pulse V_Sync rising edge and
// regenerates porch-corrected active-low syncs, Active_Video and aligned counts.
module vga_sync_porch #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_BACK_PORCH  = 33,
  parameter int COL_W         = 10,
  parameter int ROW_W         = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             H_Sync,
  input  logic             V_Sync,
  output logic             H_Sync_Out,
  output logic             V_Sync_Out,
  output logic             Active_Video,
  output logic [COL_W-1:0] Col_Count,
  output logic [ROW_W-1:0] Row_Count,
  output logic             Locked
);

  // Bounds are folded to counter width at elaboration so no runtime subtraction can underflow.
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [COL_W-1:0] COL_ACTIVE   = COL_W'(ACTIVE_COLS);
  localparam logic [ROW_W-1:0] ROW_ACTIVE   = ROW_W'(ACTIVE_ROWS);
  localparam logic [COL_W-1:0] H_SYNC_FIRST = COL_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [COL_W-1:0] H_SYNC_LAST  = COL_W'(TOTAL_COLS - H_BACK_PORCH - 1);
  localparam logic [ROW_W-1:0] V_SYNC_FIRST = ROW_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [ROW_W-1:0] V_SYNC_LAST  = ROW_W'(TOTAL_ROWS - V_BACK_PORCH - 1);

  logic             r_H1;
  logic             r_V1;
  logic [COL_W-1:0] r_Col;
  logic [ROW_W-1:0] r_Row;

  logic             frame_start;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_next;
  logic             locked_next;

  logic             active_next;
  logic             h_sync_next;
  logic             v_sync_next;

  // H_Sync is kept only as an aligned debug tap; position comes from the counter.
  logic             h_sync_unused;
  assign h_sync_unused = r_H1;

  assign frame_start = V_Sync && !r_V1;

  always_comb begin
    col_next    = r_Col;
    row_next    = r_Row;
    locked_next = Locked;
    if (frame_start) begin
      col_next    = '0;
      row_next    = '0;
      locked_next = 1'b1;
    end else if (Locked) begin
      if (r_Col == COL_LAST) begin
        col_next = '0;
        if (r_Row == ROW_LAST) begin
          row_next = '0;
        end else begin
          row_next = r_Row + 1'b1;
        end
      end else begin
        col_next = r_Col + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_H1   <= 1'b1;
      r_V1   <= 1'b1;
      r_Col  <= '0;
      r_Row  <= '0;
      Locked <= 1'b0;
    end else begin
      r_H1   <= H_Sync;
      r_V1   <= V_Sync;
      r_Col  <= col_next;
      r_Row  <= row_next;
      Locked <= locked_next;
    end
  end

  always_comb begin
    active_next = Locked && (r_Col < COL_ACTIVE) && (r_Row < ROW_ACTIVE);
    h_sync_next = !(Locked && (r_Col >= H_SYNC_FIRST) && (r_Col <= H_SYNC_LAST));
    v_sync_next = !(Locked && (r_Row >= V_SYNC_FIRST) && (r_Row <= V_SYNC_LAST));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      H_Sync_Out   <= 1'b1;
      V_Sync_Out   <= 1'b1;
      Active_Video <= 1'b0;
      Col_Count    <= '0;
      Row_Count    <= '0;
    end else begin
      H_Sync_Out   <= h_sync_next;
      V_Sync_Out   <= v_sync_next;
      Active_Video <= active_next;
      Col_Count    <= r_Col;
      Row_Count    <= r_Row;
    end
  end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch on a shrunken raster: a Sync_Pulse-like source, a
// frame-offset reference model checked every cycle, and hand-computed pins.
module tb_vga_sync_porch;

  localparam int TC    = 20;
  localparam int TR    = 13;
  localparam int AC    = 12;
  localparam int AR    = 8;
  localparam int HFP   = 2;
  localparam int HBP   = 3;
  localparam int VFP   = 1;
  localparam int VBP   = 2;
  localparam int CW    = 5;
  localparam int RW    = 4;
  localparam int FRAME = TC * TR;

  logic          CLK;
  logic          RST;
  logic          H_Sync;
  logic          V_Sync;
  logic          H_Sync_Out;
  logic          V_Sync_Out;
  logic          Active_Video;
  logic [CW-1:0] Col_Count;
  logic [RW-1:0] Row_Count;
  logic          Locked;

  vga_sync_porch #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP), .V_FRONT_PORCH(VFP), .V_BACK_PORCH(VBP),
    .COL_W(CW), .ROW_W(RW)
  ) dut (
    .CLK(CLK), .RST(RST), .H_Sync(H_Sync), .V_Sync(V_Sync),
    .H_Sync_Out(H_Sync_Out), .V_Sync_Out(V_Sync_Out), .Active_Video(Active_Video),
    .Col_Count(Col_Count), .Row_Count(Row_Count), .Locked(Locked)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  int sc = 0;
  int sr = 0;

  // Reference: position is just the number of clocks since the last frame start, mod the frame.
  logic m_locked = 1'b0;
  logic m_prev_v = 1'b1;
  int   m_k      = 0;
  logic e_hs = 1'b1, e_vs = 1'b1, e_av = 1'b0, e_locked = 1'b0;
  int   e_col = 0, e_row = 0;

  always @(posedge CLK) begin
    int c;
    int r;
    if (RST) begin
      m_prev_v <= 1'b1;
      m_locked <= 1'b0;
      m_k      <= 0;
      e_hs     <= 1'b1;
      e_vs     <= 1'b1;
      e_av     <= 1'b0;
      e_col    <= 0;
      e_row    <= 0;
      e_locked <= 1'b0;
    end else begin
      c = m_k % TC;
      r = m_k / TC;
      e_col <= c;
      e_row <= r;
      e_av  <= m_locked && (c < AC) && (r < AR);
      e_hs  <= !(m_locked && (c >= AC + HFP) && (c <= TC - HBP - 1));
      e_vs  <= !(m_locked && (r >= AR + VFP) && (r <= TR - VBP - 1));
      if (V_Sync && !m_prev_v) begin
        m_locked <= 1'b1;
        m_k      <= 0;
        e_locked <= 1'b1;
      end else begin
        if (m_locked) m_k <= (m_k + 1) % FRAME;
        e_locked <= m_locked;
      end
      m_prev_v <= V_Sync;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (check_en) begin
      check_output("model_hsync",  {31'b0, H_Sync_Out},   {31'b0, e_hs});
      check_output("model_vsync",  {31'b0, V_Sync_Out},   {31'b0, e_vs});
      check_output("model_active", {31'b0, Active_Video}, {31'b0, e_av});
      check_output("model_locked", {31'b0, Locked},       {31'b0, e_locked});
      check_output("model_col",    {27'b0, Col_Count},    32'(e_col));
      check_output("model_row",    {28'b0, Row_Count},    32'(e_row));
    end
  end

  // One source pixel per clock, driven on the falling edge.
  task automatic step(output bit rise);
    logic nv;
    @(negedge CLK);
    nv     = (sr < AR);
    rise   = nv && !V_Sync;
    H_Sync = (sc < AC);
    V_Sync = nv;
    if (sc == TC - 1) begin
      sc = 0;
      sr = (sr == TR - 1) ? 0 : sr + 1;
    end else begin
      sc++;
    end
  endtask

  task automatic glitch_step();
    @(negedge CLK);
    H_Sync = 1'b0;
    V_Sync = 1'b0;
    sc = 0;
    sr = 0;
  endtask

  task automatic wait_rise(input string name);
    bit rise;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(rise);
      found = rise;
    end
    check_output(name, {31'b0, found}, 32'd1);
  endtask

  initial begin
    bit rise;
    int av_cnt, hs_cnt, vs_cnt, hs_line_cnt, first_hs_col;
    bit found;

    RST = 1'b1; H_Sync = 1'b1; V_Sync = 1'b1;
    @(negedge CLK);
    check_en = 1'b1;
    repeat (4) @(negedge CLK);
    check_output("rst_hsync",  {31'b0, H_Sync_Out},   32'd1);
    check_output("rst_vsync",  {31'b0, V_Sync_Out},   32'd1);
    check_output("rst_active", {31'b0, Active_Video}, 32'd0);
    check_output("rst_locked", {31'b0, Locked},       32'd0);

    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check_output("vhigh_at_release_locked", {31'b0, Locked}, 32'd0);

    sr = AR; sc = 0;
    wait_rise("first_rise_seen");
    step(rise);
    check_output("lock_t1_locked", {31'b0, Locked}, 32'd1);
    step(rise);
    check_output("lock_t2_col",    {27'b0, Col_Count},    32'd0);
    check_output("lock_t2_row",    {28'b0, Row_Count},    32'd0);
    check_output("lock_t2_active", {31'b0, Active_Video}, 32'd1);

    av_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_line_cnt = 0; first_hs_col = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (Active_Video) av_cnt++;
      if (!H_Sync_Out) begin
        hs_cnt++;
        if (i < TC) hs_line_cnt++;
        if (first_hs_col < 0) first_hs_col = int'(Col_Count);
      end
      if (!V_Sync_Out) vs_cnt++;
      if (i == FRAME - 1) begin
        check_output("last_pos_col", {27'b0, Col_Count}, 32'd19);
        check_output("last_pos_row", {28'b0, Row_Count}, 32'd12);
      end
      step(rise);
    end
    check_output("wrap_col",       {27'b0, Col_Count}, 32'd0);
    check_output("wrap_row",       {28'b0, Row_Count}, 32'd0);
    check_output("frame_active",   32'(av_cnt),        32'd96);
    check_output("frame_hs_low",   32'(hs_cnt),        32'd39);
    check_output("line_hs_low",    32'(hs_line_cnt),   32'd3);
    check_output("first_hs_col",   32'(first_hs_col),  32'd14);
    check_output("frame_vs_low",   32'(vs_cnt),        32'd40);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (sr == 3 && sc == 5) found = 1'b1;
      else step(rise);
    end
    check_output("resync_point_reached", {31'b0, found}, 32'd1);
    glitch_step();
    step(rise);
    check_output("resync_rise", {31'b0, rise}, 32'd1);
    step(rise);
    step(rise);
    check_output("resync_col",    {27'b0, Col_Count}, 32'd0);
    check_output("resync_row",    {28'b0, Row_Count}, 32'd0);
    check_output("resync_locked", {31'b0, Locked},    32'd1);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step(rise);
      if (V_Sync_Out === 1'b0) found = 1'b1;
    end
    check_output("vsync_low_reached", {31'b0, found}, 32'd1);
    check_output("vsync_low_row", {28'b0, Row_Count}, 32'd9);
    RST = 1'b1;
    step(rise);
    RST = 1'b0;
    check_output("midrst_vsync",  {31'b0, V_Sync_Out}, 32'd1);
    check_output("midrst_locked", {31'b0, Locked},     32'd0);

    wait_rise("relock_rise_seen");
    step(rise);
    check_output("relock_locked", {31'b0, Locked}, 32'd1);
    step(rise);
    check_output("relock_col", {27'b0, Col_Count}, 32'd0);
    check_output("relock_row", {28'b0, Row_Count}, 32'd0);
    for (int i = 0; i < FRAME + 10; i++) step(rise);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_porch.md
Name: vga_sync_porch

Overview:
- Downstream consumer of the VGA Sync_Pulse stage.
- Takes its raw active-area H_Sync/V_Sync levels and recovers the column/row position from the V_Sync rising edge.
- Produces porch-corrected, active-low monitor sync pulses with a matching Active_Video flag and aligned Col/Row counts.
- Feeds the pixel/pattern stage and the VGA output pins.

Parameters:
- TOTAL_COLS, 800, pixels per line including blanking.
- TOTAL_ROWS, 525, lines per frame including blanking.
- ACTIVE_COLS, 640, visible pixels per line.
- ACTIVE_ROWS, 480, visible lines per frame.
- H_FRONT_PORCH, 16, columns between the end of active video and the start of the H sync pulse.
- H_BACK_PORCH, 48, columns between the end of the H sync pulse and the end of the line.
- V_FRONT_PORCH, 10, rows between the end of active video and the start of the V sync pulse.
- V_BACK_PORCH, 33, rows between the end of the V sync pulse and the end of the frame.
- COL_W, 10, column counter width; must satisfy 2^COL_W >= TOTAL_COLS.
- ROW_W, 10, row counter width; must satisfy 2^ROW_W >= TOTAL_ROWS.

Ports:
- CLK  in  1  pixel clock (25 MHz nominal).
- RST  in  1  reset; synchronous, active-high.
- H_Sync  in  1  raw line level from Sync_Pulse; high for input columns 0..ACTIVE_COLS-1.
- V_Sync  in  1  raw frame level from Sync_Pulse; high for input rows 0..ACTIVE_ROWS-1.
- H_Sync_Out  out  1  porch-corrected horizontal sync, active-low.
- V_Sync_Out  out  1  porch-corrected vertical sync, active-low.
- Active_Video  out  1  high while the aligned position is inside the visible area.
- Col_Count  out  COL_W  column aligned with the sync outputs.
- Row_Count  out  ROW_W  row aligned with the sync outputs.
- Locked  out  1  high once the first frame start has been detected.

Behaviour:
- Clock and reset: single clock domain, CLK. RST is synchronous and active-high, sampled on the CLK rising edge. RST has priority over all other logic.
- Reset values:
  - H_Sync_Out = 1, V_Sync_Out = 1.
  - Active_Video = 0, Col_Count = 0, Row_Count = 0, Locked = 0.
  - Internal input registers r_H1 = 1 and r_V1 = 1. Because r_V1 resets to 1, a V_Sync already high at reset release is not a frame start.
- Stage 1 (input register plus counters):
  - r_H1 <= H_Sync and r_V1 <= V_Sync every cycle.
  - Frame start = (V_Sync == 1 && r_V1 == 0).
  - On frame start: r_Col <= 0, r_Row <= 0, Locked <= 1.
  - Otherwise, when Locked = 1:
    - r_Col increments.
    - At r_Col == TOTAL_COLS-1, r_Col wraps to 0 and r_Row increments.
    - At r_Row == TOTAL_ROWS-1 with a column wrap, r_Row wraps to 0.
  - When Locked = 0 and no frame start occurs, the counters hold at 0.
- Stage 2 (output register, computed from r_Col/r_Row):
  - Col_Count <= r_Col; Row_Count <= r_Row.
  - Active_Video <= Locked && r_Col < ACTIVE_COLS && r_Row < ACTIVE_ROWS.
  - H_Sync_Out <= 0 iff Locked && ACTIVE_COLS+H_FRONT_PORCH <= r_Col <= TOTAL_COLS-H_BACK_PORCH-1; otherwise 1. With defaults this is columns 656..751, a 96-clock pulse.
  - V_Sync_Out <= 0 iff Locked && ACTIVE_ROWS+V_FRONT_PORCH <= r_Row <= TOTAL_ROWS-V_BACK_PORCH-1; otherwise 1. With defaults this is rows 490..491, 2 lines.
  - While unlocked, stage 2 holds its idle values.
- Latency: every output is exactly 2 CLK cycles after the input sample it corresponds to. Input column 0 of row 0 appears as Col_Count = 0, Row_Count = 0 two edges later.
- Frame start coinciding with a counter wrap: frame start wins, and the counters go to 0,0.
- Mid-frame V_Sync rising edge (glitch or upstream restart): the block resynchronises immediately to 0,0. Locked stays 1.
- H_Sync is registered for alignment/debug only; column position derives solely from the counter.
- RST mid-frame: the next edge restores all reset values and clears Locked. Output resumes only after a fresh V_Sync low→high edge.
- Wrap arithmetic: the counters never exceed TOTAL_COLS-1 / TOTAL_ROWS-1. No unsigned underflow is permitted in the porch comparisons.

Test Plan:
- Reset hold: RST = 1 for 5 cycles with V_Sync = 1 -> H_Sync_Out = 1, V_Sync_Out = 1, Active_Video = 0, Locked = 0. After RST drops with V_Sync still 1 -> Locked stays 0.
- First lock: drive a Sync_Pulse-equivalent model. At the first V_Sync 0→1 edge (cycle T) -> Locked = 1 at T+1. At T+2: Col_Count = 0, Row_Count = 0, Active_Video = 1.
- Line timing, default parameters:
  - H_Sync_Out low for exactly 96 clocks per line, first low at Col_Count = 656.
  - Active_Video high for 640 clocks per visible line.
  - Line period 800 clocks (32 µs at 40 ns).
- Frame timing:
  - V_Sync_Out low only for Row_Count 490..491, i.e. 1600 clocks.
  - Frame period 420000 clocks.
  - Row_Count wraps 524→0 exactly as the next V_Sync edge arrives.
- Resync: inject a V_Sync low→high edge at input row 100, column 300 -> two cycles later Col_Count = 0, Row_Count = 0. No extra sync pulse and no X.
- Reset mid-frame: assert RST for 1 cycle during Row_Count 490 (V_Sync_Out = 0) -> next edge V_Sync_Out = 1, Locked = 0. Relock occurs on the next V_Sync rising edge.
